// File: rtl/seg_scan_pkg.sv
// Shared types and helpers for the 4-digit seven-segment scan controller.
package seg_scan_pkg;

    localparam int unsigned NUM_DIG      = 4;
    localparam int unsigned SLOT_W       = 2;
    localparam int unsigned SLOT_CYC_DEF = 50000;
    localparam int unsigned CNT_W        = $clog2(SLOT_CYC_DEF);

    localparam logic [NUM_DIG-1:0] EN_OFF = 4'b1111;

    // One displayed frame: four nibbles, four dots, four digit enables.
    typedef struct packed {
        logic [4*NUM_DIG-1:0] data;
        logic [NUM_DIG-1:0]   dot;
        logic [NUM_DIG-1:0]   en;
    } frame_t;

    // Active-low one-hot digit select for a slot.
    function automatic logic [NUM_DIG-1:0] slot_sel(input logic [SLOT_W-1:0] slot);
        return ~(4'b0001 << slot);
    endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// Slot/cycle counters for the digit scan, with enable park and blank/boundary flags.
module seg_slot_timer
    import seg_scan_pkg::*;
#(
    parameter int unsigned SLOT_CYC   = 50000,
    parameter int unsigned BLANK_CYC  = 500,
    localparam int unsigned SLOT_CNT_W = (SLOT_CYC > 2) ? $clog2(SLOT_CYC) : 1
) (
    input  logic              FPGA_CLK,
    input  logic              FPGA_RST_N,
    input  logic              enable,
    output logic [SLOT_W-1:0] slot,
    output logic              blank_c,
    output logic              boundary_c
);

    localparam logic [SLOT_CNT_W-1:0] CNT_MAX   = SLOT_CNT_W'(SLOT_CYC - 1);
    localparam logic [SLOT_CNT_W-1:0] CNT_BLANK = SLOT_CNT_W'(BLANK_CYC);

    logic [SLOT_CNT_W-1:0] cnt;

    // Disabled: park at slot 0, cnt 0 so re-enable starts a fresh frame.
    always_ff @(posedge FPGA_CLK or negedge FPGA_RST_N) begin
        if (!FPGA_RST_N) begin
            cnt  <= '0;
            slot <= '0;
        end else if (!enable) begin
            cnt  <= '0;
            slot <= '0;
        end else if (cnt == CNT_MAX) begin
            cnt  <= '0;
            slot <= slot + SLOT_W'(1);
        end else begin
            cnt  <= cnt + SLOT_CNT_W'(1);
        end
    end

    assign blank_c    = (cnt < CNT_BLANK);
    assign boundary_c = enable && (slot == SLOT_W'(3)) && (cnt == CNT_MAX);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 4-digit scan with double-buffered frame and anti-ghost blanking.
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int unsigned SLOT_CYC  = 50000,
    parameter int unsigned BLANK_CYC = 500
) (
    input  logic                 FPGA_CLK,
    input  logic                 FPGA_RST_N,
    input  logic                 enable,
    input  logic                 load,
    input  logic [4*NUM_DIG-1:0] data_in,
    input  logic [NUM_DIG-1:0]   dot_in,
    input  logic [NUM_DIG-1:0]   digit_en,
    output logic [3:0]           data_seg,
    output logic [NUM_DIG-1:0]   en_seg,
    output logic                 dt,
    output logic                 frame_done
);

    logic [SLOT_W-1:0] slot;
    logic              blank_c;
    logic              boundary_c;
    logic              commit_c;

    frame_t in_frame;
    frame_t pending;
    frame_t shadow;
    logic   pending_valid;

    logic [3:0]         data_seg_nxt;
    logic [NUM_DIG-1:0] en_seg_nxt;
    logic               dt_nxt;
    logic               frame_done_nxt;

    seg_slot_timer #(
        .SLOT_CYC  (SLOT_CYC),
        .BLANK_CYC (BLANK_CYC)
    ) u_timer (
        .FPGA_CLK   (FPGA_CLK),
        .FPGA_RST_N (FPGA_RST_N),
        .enable     (enable),
        .slot       (slot),
        .blank_c    (blank_c),
        .boundary_c (boundary_c)
    );

    assign in_frame = '{data: data_in, dot: dot_in, en: digit_en};
    // While disabled every cycle acts as a boundary, so re-enable shows the latest data.
    assign commit_c = boundary_c || !enable;

    // Pending/shadow double buffer; a load on the commit edge bypasses pending.
    always_ff @(posedge FPGA_CLK or negedge FPGA_RST_N) begin
        if (!FPGA_RST_N) begin
            pending       <= '0;
            shadow        <= '0;
            pending_valid <= 1'b0;
        end else begin
            if (load) begin
                pending <= in_frame;
            end
            if (commit_c) begin
                if (load) begin
                    shadow <= in_frame;
                end else if (pending_valid) begin
                    shadow <= pending;
                end
                pending_valid <= 1'b0;
            end else if (load) begin
                pending_valid <= 1'b1;
            end
        end
    end

    // Next output values from the current slot position and shadow frame.
    always_comb begin
        data_seg_nxt   = shadow.data[{slot, 2'b00} +: 4];
        en_seg_nxt     = EN_OFF;
        dt_nxt         = 1'b1;
        frame_done_nxt = boundary_c;
        if (!enable) begin
            data_seg_nxt = shadow.data[3:0];
        end else if (!blank_c && shadow.en[slot]) begin
            en_seg_nxt = slot_sel(slot);
            dt_nxt     = ~shadow.dot[slot];
        end
    end

    always_ff @(posedge FPGA_CLK or negedge FPGA_RST_N) begin
        if (!FPGA_RST_N) begin
            data_seg   <= '0;
            en_seg     <= EN_OFF;
            dt         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            data_seg   <= data_seg_nxt;
            en_seg     <= en_seg_nxt;
            dt         <= dt_nxt;
            frame_done <= frame_done_nxt;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with SLOT_CYC=8, BLANK_CYC=2 (32-cycle frame).
module tb_seg_scan_ctrl;

    logic        FPGA_CLK;
    logic        FPGA_RST_N = 1'b0;
    logic        enable     = 1'b1;
    logic        load       = 1'b0;
    logic [15:0] data_in    = '0;
    logic [3:0]  dot_in     = '0;
    logic [3:0]  digit_en   = '0;
    logic [3:0]  data_seg;
    logic [3:0]  en_seg;
    logic        dt;
    logic        frame_done;

    int n_tests = 0;
    int n_fail  = 0;
    int pos     = 0;   // frame position (slot*8+cnt) the next edge will sample
    int last    = -1;  // position the outputs now reflect; -1 when parked/reset

    logic [3:0] sel_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    seg_scan_ctrl #(
        .SLOT_CYC  (8),
        .BLANK_CYC (2)
    ) dut (
        .FPGA_CLK   (FPGA_CLK),
        .FPGA_RST_N (FPGA_RST_N),
        .enable     (enable),
        .load       (load),
        .data_in    (data_in),
        .dot_in     (dot_in),
        .digit_en   (digit_en),
        .data_seg   (data_seg),
        .en_seg     (en_seg),
        .dt         (dt),
        .frame_done (frame_done)
    );

    initial FPGA_CLK = 1'b0;
    always #5 FPGA_CLK = ~FPGA_CLK;

    task automatic tick();
        @(posedge FPGA_CLK);
        #1;
        if (!FPGA_RST_N || !enable) begin
            last = -1;
            pos  = 0;
        end else begin
            last = pos;
            pos  = (pos + 1) % 32;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge FPGA_CLK);
        #1;
        n_tests++;
        if ({en_seg, data_seg, dt, frame_done} !== {4'b1111, 4'h0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_values got=%b/%h/%b/%b exp=1111/0/1/0", en_seg, data_seg, dt, frame_done);
        end
        FPGA_RST_N = 1'b1;
        pos = 0;
    endtask

    task automatic test_scan();
        logic [9:0] exp;
        int s, c;
        load = 1'b1; data_in = 16'h4321; digit_en = 4'hF; dot_in = 4'h0;
        tick();
        load = 1'b0;
        for (int i = 1; i < 32; i++) begin
            tick();
            exp = {4'b1111, 4'h0, 1'b1, last == 31};
            n_tests++;
            if ({en_seg, data_seg, dt, frame_done} !== exp) begin
                n_fail++;
                $display("FAIL scan_preload pos=%0d got=%b exp=%b", last, {en_seg, data_seg, dt, frame_done}, exp);
            end
        end
        for (int i = 0; i < 32; i++) begin
            tick();
            s = last / 8; c = last % 8;
            exp = {(c < 2) ? 4'b1111 : sel_tab[s], 4'(s + 1), 1'b1, last == 31};
            n_tests++;
            if ({en_seg, data_seg, dt, frame_done} !== exp) begin
                n_fail++;
                $display("FAIL scan_frame pos=%0d got=%b exp=%b", last, {en_seg, data_seg, dt, frame_done}, exp);
            end
        end
    endtask

    task automatic test_pending_overwrite();
        logic [9:0] exp;
        int s, c;
        for (int i = 0; i < 32; i++) begin
            if (pos == 9) begin
                load = 1'b1; data_in = 16'hAAAA;
            end else if (pos == 18) begin
                load = 1'b1; data_in = 16'h5555;
            end else begin
                load = 1'b0;
            end
            tick();
            s = last / 8; c = last % 8;
            exp = {(c < 2) ? 4'b1111 : sel_tab[s], 4'(s + 1), 1'b1, last == 31};
            n_tests++;
            if ({en_seg, data_seg, dt, frame_done} !== exp) begin
                n_fail++;
                $display("FAIL pend_hold pos=%0d got=%b exp=%b", last, {en_seg, data_seg, dt, frame_done}, exp);
            end
        end
        load = 1'b0;
        for (int i = 0; i < 32; i++) begin
            tick();
            s = last / 8; c = last % 8;
            exp = {(c < 2) ? 4'b1111 : sel_tab[s], 4'h5, 1'b1, last == 31};
            n_tests++;
            if ({en_seg, data_seg, dt, frame_done} !== exp) begin
                n_fail++;
                $display("FAIL pend_last_wins pos=%0d got=%b exp=%b", last, {en_seg, data_seg, dt, frame_done}, exp);
            end
        end
    endtask

    task automatic test_boundary_load();
        logic [9:0] exp;
        logic [3:0] dig [4] = '{4'h0, 4'hF, 4'h0, 4'h0};
        int s, c;
        data_in = 16'h00F0;
        for (int i = 0; i < 32; i++) begin
            load = (pos == 31);
            tick();
            s = last / 8; c = last % 8;
            exp = {(c < 2) ? 4'b1111 : sel_tab[s], 4'h5, 1'b1, last == 31};
            n_tests++;
            if ({en_seg, data_seg, dt, frame_done} !== exp) begin
                n_fail++;
                $display("FAIL bload_before pos=%0d got=%b exp=%b", last, {en_seg, data_seg, dt, frame_done}, exp);
            end
        end
        load = 1'b0;
        for (int i = 0; i < 32; i++) begin
            tick();
            s = last / 8; c = last % 8;
            exp = {(c < 2) ? 4'b1111 : sel_tab[s], dig[s], 1'b1, last == 31};
            n_tests++;
            if ({en_seg, data_seg, dt, frame_done} !== exp) begin
                n_fail++;
                $display("FAIL bload_direct pos=%0d got=%b exp=%b", last, {en_seg, data_seg, dt, frame_done}, exp);
            end
        end
    endtask

    task automatic test_digit_en();
        logic [9:0] exp;
        logic [3:0] exp_en;
        logic [3:0] dig [4] = '{4'h0, 4'hF, 4'h0, 4'h0};
        int s, c;
        data_in = 16'h8765; digit_en = 4'b0101; dot_in = 4'b0001;
        for (int i = 0; i < 32; i++) begin
            load = (pos == 3);
            tick();
            s = last / 8; c = last % 8;
            exp = {(c < 2) ? 4'b1111 : sel_tab[s], dig[s], 1'b1, last == 31};
            n_tests++;
            if ({en_seg, data_seg, dt, frame_done} !== exp) begin
                n_fail++;
                $display("FAIL den_before pos=%0d got=%b exp=%b", last, {en_seg, data_seg, dt, frame_done}, exp);
            end
        end
        load = 1'b0;
        for (int i = 0; i < 32; i++) begin
            tick();
            s = last / 8; c = last % 8;
            exp_en = (c >= 2 && (s == 0 || s == 2)) ? sel_tab[s] : 4'b1111;
            exp = {exp_en, 4'(s + 5), !(s == 0 && c >= 2), last == 31};
            n_tests++;
            if ({en_seg, data_seg, dt, frame_done} !== exp) begin
                n_fail++;
                $display("FAIL den_frame pos=%0d got=%b exp=%b", last, {en_seg, data_seg, dt, frame_done}, exp);
            end
        end
    endtask

    task automatic test_disable();
        logic [9:0] exp [7] = '{
            {4'b1111, 4'h5, 1'b1, 1'b0},   // first disabled edge: old shadow nibble 0
            {4'b1111, 4'hC, 1'b1, 1'b0},   // pending committed while disabled
            {4'b1111, 4'hC, 1'b1, 1'b0},
            {4'b1111, 4'hC, 1'b1, 1'b0},   // re-enable edge E0, blank
            {4'b1111, 4'hC, 1'b1, 1'b0},
            {4'b1110, 4'hC, 1'b1, 1'b0},   // E0+2: digit 0 lit
            {4'b1110, 4'hC, 1'b1, 1'b0}
        };
        for (int i = 0; i < 32 && pos != 19; i++) tick();
        load = 1'b1; data_in = 16'h000C; digit_en = 4'b0001; dot_in = 4'b0000;
        tick();
        load = 1'b0;
        tick();
        n_tests++;
        if (en_seg !== 4'b1011 || last != 20) begin
            n_fail++;
            $display("FAIL dis_pre pos=%0d got=%b exp=1011", last, en_seg);
        end
        for (int i = 0; i < 7; i++) begin
            enable = (i >= 3);
            tick();
            n_tests++;
            if ({en_seg, data_seg, dt, frame_done} !== exp[i]) begin
                n_fail++;
                $display("FAIL disable step=%0d got=%b exp=%b", i, {en_seg, data_seg, dt, frame_done}, exp[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [9:0] exp;
        @(posedge FPGA_CLK);
        #4;
        FPGA_RST_N = 1'b0;
        #1;
        n_tests++;
        if ({en_seg, data_seg, dt, frame_done} !== {4'b1111, 4'h0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset got=%b exp=1111000010", {en_seg, data_seg, dt, frame_done});
        end
        @(posedge FPGA_CLK);
        #1;
        FPGA_RST_N = 1'b1;
        pos = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            exp = {4'b1111, 4'h0, 1'b1, last == 31};
            n_tests++;
            if ({en_seg, data_seg, dt, frame_done} !== exp) begin
                n_fail++;
                $display("FAIL post_reset pos=%0d got=%b exp=%b", last, {en_seg, data_seg, dt, frame_done}, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_pending_overwrite();
        test_boundary_load();
        test_digit_en();
        test_disable();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
